// File: rtl/jogo_sequenciador.sv
// Simon-style sequencer: grows an LFSR colour sequence, plays it on four LEDs, checks button echoes.
// Optional WAIT_IN timeout when JOGO_TIMEOUT_EN is defined.
module jogo_sequenciador #(
  parameter int          MAX_LEN     = 16,
  parameter int          STEP_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 12500000,
  parameter logic [15:0] SEED        = 16'hACE1
`ifdef JOGO_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 125000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] botao,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       led4,
  output logic [5:0] nivel,
  output logic       ocupado,
  output logic       vitoria,
  output logic       erro
);

  localparam int STEP_GAP_MAX = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
`ifdef JOGO_TIMEOUT_EN
  localparam int CYC_MAX = (STEP_GAP_MAX > TIMEOUT_CYCLES) ? STEP_GAP_MAX : TIMEOUT_CYCLES;
`else
  localparam int CYC_MAX = STEP_GAP_MAX;
`endif
  localparam int TW = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
  localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] T_STEP  = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
`ifdef JOGO_TIMEOUT_EN
  localparam logic [TW-1:0] T_TMOUT = TW'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [5:0]    LEN_MAX = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_ECHO, S_WIN, S_LOSE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [15:0]   lfsr, lfsr_nxt, lfsr_adv;
  logic [1:0]    seq [MAX_LEN];
  logic          seq_we;
  logic [5:0]    idx, idx_nxt, idx_p1, nivel_nxt;
  logic [3:0]    leds, leds_nxt;
  logic [3:0]    botao_q, edges;
  logic          one_edge;
  logic [1:0]    press_col, cur_col, nxt_col, add_col;

  function automatic logic [3:0] dec(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign lfsr_adv  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign edges     = botao & ~botao_q;
  assign one_edge  = (edges != 4'd0) && ((edges & (edges - 4'd1)) == 4'd0);
  // botao[3] is colour 0 ... botao[0] is colour 3
  assign press_col = {edges[1] | edges[0], edges[2] | edges[0]};
  assign idx_p1    = idx + 6'd1;
  assign cur_col   = seq[idx[IW-1:0]];
  assign nxt_col   = seq[idx_p1[IW-1:0]];
  // first playback step of round 1 reads the colour being written this very cycle
  assign add_col   = (nivel == 6'd0) ? lfsr_adv[1:0] : seq[0];

  assign {led4, led3, led2, led1} = leds;
  assign ocupado = !(state inside {S_IDLE, S_WIN, S_LOSE});
  assign vitoria = (state == S_WIN);
  assign erro    = (state == S_LOSE);

  always_ff @(posedge clk) begin
    botao_q <= botao;
  end

  always_ff @(posedge clk) begin
    if (seq_we) seq[nivel[IW-1:0]] <= lfsr_adv[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      lfsr  <= SEED;
      nivel <= '0;
      idx   <= '0;
      leds  <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      lfsr  <= lfsr_nxt;
      nivel <= nivel_nxt;
      idx   <= idx_nxt;
      leds  <= leds_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = (timer != '0) ? timer - TW'(1) : timer;
    lfsr_nxt  = lfsr;
    nivel_nxt = nivel;
    idx_nxt   = idx;
    leds_nxt  = leds;
    seq_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nivel_nxt = '0;
          leds_nxt  = '0;
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        lfsr_nxt  = lfsr_adv;
        seq_we    = 1'b1;
        nivel_nxt = nivel + 6'd1;
        idx_nxt   = '0;
        leds_nxt  = dec(add_col);
        timer_nxt = T_STEP;
        state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer == '0) begin
          leds_nxt  = '0;
          timer_nxt = T_GAP;
          state_nxt = S_SHOW_OFF;
        end
      end
      S_SHOW_OFF: begin
        if (timer == '0) begin
          if (idx_p1 == nivel) begin
            idx_nxt   = '0;
            leds_nxt  = '0;
`ifdef JOGO_TIMEOUT_EN
            timer_nxt = T_TMOUT;
`endif
            state_nxt = S_WAIT_IN;
          end else begin
            idx_nxt   = idx_p1;
            leds_nxt  = dec(nxt_col);
            timer_nxt = T_STEP;
            state_nxt = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        if (edges != 4'd0) begin
          timer_nxt = T_STEP;
          if (one_edge && (press_col == cur_col)) begin
            leds_nxt  = dec(cur_col);
            state_nxt = S_ECHO;
          end else begin
            leds_nxt  = 4'b1111;
            state_nxt = S_LOSE;
          end
        end
`ifdef JOGO_TIMEOUT_EN
        else if (timer == '0) begin
          leds_nxt  = 4'b1111;
          timer_nxt = T_STEP;
          state_nxt = S_LOSE;
        end
`endif
      end
      S_ECHO: begin
        if (timer == '0) begin
          if (idx_p1 < nivel) begin
            idx_nxt   = idx_p1;
            leds_nxt  = '0;
`ifdef JOGO_TIMEOUT_EN
            timer_nxt = T_TMOUT;
`endif
            state_nxt = S_WAIT_IN;
          end else if (nivel == LEN_MAX) begin
            leds_nxt  = 4'b1111;
            timer_nxt = T_STEP;
            state_nxt = S_WIN;
          end else begin
            leds_nxt  = '0;
            state_nxt = S_ADD;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          nivel_nxt = '0;
          leds_nxt  = '0;
          state_nxt = S_ADD;
        end else if (timer == '0) begin
          leds_nxt  = ~leds;
          timer_nxt = T_STEP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jogo_sequenciador.sv
// Scoreboard bench for jogo_sequenciador: stimulus pushes expected LED pulses and game outcomes,
// independent monitors pop and compare them as the panel shows them.
module tb_jogo_sequenciador;

  localparam int          MAX_LEN = 4;
  localparam int          STEP    = 4;
  localparam int          GAP     = 2;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef JOGO_TIMEOUT_EN
  localparam int          HOLD_MAX = 8;
`else
  localparam int          HOLD_MAX = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] botao;
  logic       led1, led2, led3, led4;
  logic [5:0] nivel;
  logic       ocupado, vitoria, erro;
  logic [3:0] leds_v;

  always #5 clk = ~clk;
  assign leds_v = {led4, led3, led2, led1};

  jogo_sequenciador #(
    .MAX_LEN(MAX_LEN), .STEP_CYCLES(STEP), .GAP_CYCLES(GAP), .SEED(SEED)
`ifdef JOGO_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .botao(botao),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4),
    .nivel(nivel), .ocupado(ocupado), .vitoria(vitoria), .erro(erro)
  );

  typedef struct { bit vit; bit err; int lvl; } outcome_t;

  int         exp_pulse_q[$];
  outcome_t   exp_out_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [15:0] model_lfsr;
  int         model_seq[$];
  int         dark_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int fb;
    fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((fb << 15) | (x >> 1));
  endfunction

  // Pulse monitor: every single-LED lighting must match the next expected colour and last STEP cycles.
  bit         in_pulse = 1'b0;
  logic [3:0] pulse_val = 4'd0;
  int         plen = 0;
  int         pc;
  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
      plen     = 0;
      dark_cnt = 0;
    end else begin
      if (leds_v == 4'd0) dark_cnt++; else dark_cnt = 0;
      if (in_pulse && leds_v == pulse_val) plen++;
      else begin
        if (in_pulse) begin
          if (exp_pulse_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: leds %b lit %0d cycles, expected no pulse", pulse_val, plen);
          end else begin
            pc = exp_pulse_q.pop_front();
            chk("pulse_led", 32'(pulse_val), 32'(4'b0001 << pc));
            chk("pulse_len", 32'(plen), 32'(STEP));
          end
        end
        in_pulse  = ($countones(leds_v) == 1);
        pulse_val = leds_v;
        plen      = 1;
      end
    end
  end

  // Outcome monitor: entry into WIN/LOSE and the first blink toggle.
  bit       fin_prev = 1'b0;
  int       fin_cnt = 0;
  outcome_t eo;
  always @(negedge clk) begin
    if (rst) begin
      fin_prev = 1'b0;
      fin_cnt  = 0;
    end else begin
      if ((vitoria | erro) && !fin_prev) begin
        fin_cnt = 0;
        if (exp_out_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_outcome: vitoria=%0b erro=%0b nivel=%0d, expected game running", vitoria, erro, nivel);
        end else begin
          eo = exp_out_q.pop_front();
          chk("out_vitoria", 32'(vitoria), 32'(eo.vit));
          chk("out_erro", 32'(erro), 32'(eo.err));
          chk("out_nivel", 32'(nivel), 32'(eo.lvl));
          chk("out_leds_lit", 32'(leds_v), 32'hF);
          chk("out_ocupado", 32'(ocupado), 32'd0);
        end
      end else if (vitoria | erro) begin
        fin_cnt++;
        if (fin_cnt == STEP) chk("blink_dark", 32'(leds_v), 32'd0);
        if (fin_cnt == 2 * STEP) chk("blink_lit", 32'(leds_v), 32'hF);
      end
      fin_prev = vitoria | erro;
    end
  end

  task automatic wait_quiet(input int n, input string what);
    int k = 0;
    while (!(exp_pulse_q.size() == 0 && dark_cnt >= n) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL %s: timeout, pulses pending=%0d dark=%0d, required none pending and dark>=%0d",
               what, exp_pulse_q.size(), dark_cnt, n);
    end
  endtask

  task automatic wait_out(input string what);
    int k = 0;
    while (exp_out_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL %s: timeout, outcomes pending=%0d, required 0", what, exp_out_q.size());
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    botao = b;
    repeat (hold) @(negedge clk);
    botao = 4'd0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_nivel", 32'(nivel), 32'd0);
    chk("start_ocupado", 32'(ocupado), 32'd1);
    chk("start_leds", 32'(leds_v), 32'd0);
  endtask

  task automatic push_outcome(input bit v, input bit e, input int lvl);
    outcome_t o;
    o.vit = v; o.err = e; o.lvl = lvl;
    exp_out_q.push_back(o);
  endtask

  // fail_round 0 plays to a win; fail_botao nonzero forces that press at step 0 of fail_round.
  task automatic run_game(input int fail_round, input logic [3:0] fail_botao, input bit multi);
    int fail_step, c, hold;
    logic [3:0] b;
    fail_step = (fail_round > 0) ? int'($urandom_range(0, fail_round - 1)) : 0;
    if (fail_botao != 4'd0) fail_step = 0;
    @(negedge clk);
    pulse_start();
    model_seq.delete();
    for (int r = 1; r <= MAX_LEN; r++) begin
      model_lfsr = lfsr_step(model_lfsr);
      model_seq.push_back(int'(model_lfsr & 16'd3));
      foreach (model_seq[i]) exp_pulse_q.push_back(model_seq[i]);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int s = 0; s < r; s++) begin
        wait_quiet(GAP + 2, "reach_wait_in");
        if (r == fail_round && s == fail_step) begin
          if (fail_botao != 4'd0) b = fail_botao;
          else if (multi) begin
            do b = 4'($urandom_range(0, 15)); while ($countones(b) < 2);
          end else b = 4'(4'b1000 >> ((model_seq[s] + int'($urandom_range(1, 3))) % 4));
          push_outcome(1'b0, 1'b1, r);
          press(b, 1);
          wait_out("reach_lose");
          repeat (2 * STEP + 2) @(negedge clk);
          return;
        end
        c = model_seq[s];
        if (s == r - 1) hold = $urandom_range(1, 3);
        else if (s == 0 && r == 2) hold = HOLD_MAX;
        else hold = $urandom_range(1, HOLD_MAX);
        exp_pulse_q.push_back(c);
        if (r == MAX_LEN && s == r - 1) push_outcome(1'b1, 1'b0, MAX_LEN);
        press(4'(4'b1000 >> c), hold);
      end
      wait_quiet(1, "echo_done");
    end
    wait_out("reach_win");
    repeat (2 * STEP + 2) @(negedge clk);
  endtask

  task automatic idle_test();
    int c;
    @(negedge clk);
    pulse_start();
    model_lfsr = lfsr_step(model_lfsr);
    c = int'(model_lfsr & 16'd3);
    exp_pulse_q.push_back(c);
    wait_quiet(GAP + 2, "idle_reach_wait_in");
`ifdef JOGO_TIMEOUT_EN
    push_outcome(1'b0, 1'b1, 1);
    wait_out("timeout_lose");
`else
    repeat (40) @(negedge clk);
    chk("idle_no_erro", 32'(erro), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd1);
    push_outcome(1'b0, 1'b1, 1);
    press(4'(4'b1000 >> ((c + 1) % 4)), 1);
    wait_out("idle_wrong_lose");
`endif
    repeat (2 * STEP + 2) @(negedge clk);
  endtask

  task automatic reset_test();
    int k = 0;
    @(negedge clk);
    pulse_start();
    while (leds_v == 4'd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_show_on", 32'($countones(leds_v)), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_leds", 32'(leds_v), 32'd0);
    chk("rst_mid_nivel", 32'(nivel), 32'd0);
    chk("rst_mid_ocupado", 32'(ocupado), 32'd0);
    chk("rst_mid_flags", 32'({vitoria, erro}), 32'd0);
    exp_pulse_q.delete();
    exp_out_q.delete();
    model_lfsr = SEED;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle_ocupado", 32'(ocupado), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    botao = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_leds", 32'(leds_v), 32'd0);
    chk("reset_nivel", 32'(nivel), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_vitoria", 32'(vitoria), 32'd0);
    chk("reset_erro", 32'(erro), 32'd0);
    rst = 1'b0;
    model_lfsr = SEED;
    repeat (2) @(negedge clk);

    run_game(0, 4'd0, 1'b0);
    run_game(1, 4'b0100, 1'b0);
    run_game(2, 4'b1010, 1'b0);
    for (int g = 0; g < 5; g++)
      run_game(int'($urandom_range(0, MAX_LEN)), 4'd0, 1'($urandom_range(0, 1)));
    idle_test();
    reset_test();
    run_game(0, 4'd0, 1'b0);

    chk("pulses_drained", 32'(exp_pulse_q.size()), 32'd0);
    chk("outcomes_drained", 32'(exp_out_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
